// File: rtl/sector_buffer.sv
// rtl/sector_buffer.sv - multi-bank sector buffer between SD byte stream and consumer; optional error flags via SECTOR_BUFFER_ERR_EN
module sector_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  blk_avail,
    output logic [BANK_WIDTH:0]   full_banks
`ifdef SECTOR_BUFFER_ERR_EN
    ,
    input  logic                  err_clr,
    output logic                  wr_overflow,
    output logic                  rd_underflow
`endif
);

    localparam int MEM_WORDS = NUM_BANKS * (2 ** ADDR_WIDTH);
    localparam logic [BANK_WIDTH:0] ALL_FULL = (BANK_WIDTH + 1)'(NUM_BANKS);

    // Storage: no reset so that it maps onto block RAM
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [BANK_WIDTH-1:0] wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [BANK_WIDTH-1:0] rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
    logic [BANK_WIDTH:0]   full_q,    full_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    logic wr_accept;
    logic rd_accept;
    logic wr_done;
    logic rd_release;

    // Handshake status is derived purely from the registered full-bank count,
    // so the write bank is never one of the full banks being drained.
    assign wr_ready   = (full_q != ALL_FULL);
    assign blk_avail  = (full_q != '0);
    assign full_banks = full_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;

    assign wr_accept  = wr_en && wr_ready;
    assign rd_accept  = rd_en && blk_avail;
    assign wr_done    = wr_accept && (wr_ptr_q == '1);
    assign rd_release = rd_accept && (rd_ptr_q == '1);

    // Next-state for pointers and the full-bank counter
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        rd_bank_d = rd_bank_q;
        rd_ptr_d  = rd_ptr_q;
        full_d    = full_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_done) begin
                wr_bank_d = wr_bank_q + 1'b1;
            end
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_release) begin
                rd_bank_d = rd_bank_q + 1'b1;
            end
        end
        case ({wr_done, rd_release})
            2'b10:   full_d = full_q + 1'b1;
            2'b01:   full_d = full_q - 1'b1;
            default: full_d = full_q;
        endcase
    end

    // Pointer and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= '0;
            wr_ptr_q   <= '0;
            rd_bank_q  <= '0;
            rd_ptr_q   <= '0;
            full_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            rd_valid_q <= rd_accept;
        end
    end

    // RAM write port
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank_q, wr_ptr_q}] <= wr_data;
        end
    end

    // Registered RAM read; data holds when no read is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_accept) begin
            rd_data_q <= mem[{rd_bank_q, rd_ptr_q}];
        end
    end

`ifdef SECTOR_BUFFER_ERR_EN
    logic ovf_q, ovf_d;
    logic und_q, und_d;

    // A violation in the same cycle as a clear wins, keeping the flag set
    always_comb begin
        ovf_d = (wr_en && !wr_ready) || (ovf_q && !err_clr);
        und_d = (rd_en && !blk_avail) || (und_q && !err_clr);
    end

    // Sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            und_q <= und_d;
        end
    end

    assign wr_overflow  = ovf_q;
    assign rd_underflow = und_q;
`endif

endmodule
